// File: rtl/spdma_ctl.sv
// spdma_ctl: sprite-attribute DMA engine sharing one work-RAM port with the CPU.
// Optional macro SPDMA_FAIR_EN bounds CPU priority so DMA gets every 4th RUN cycle.
module spdma_ctl #(
    parameter logic [10:0] SRC_BASE = 11'h000,
    parameter int unsigned LEN      = 256
) (
    input  logic        CL,
    input  logic        RSTn,
    input  logic        TRG,
    input  logic [10:0] CAD,
    input  logic        CRD,
    input  logic        CWR,
    input  logic [7:0]  CWD,
    output logic [7:0]  CDO,
    output logic        CWAIT,
    output logic [10:0] MAD,
    output logic        MWE,
    output logic [7:0]  MWD,
    input  logic [7:0]  MRD,
    output logic [7:0]  DAD,
    output logic [7:0]  DWD,
    output logic        DWE,
    output logic        BUSY,
    output logic        DONE
);
    // state   | meaning
    // S_IDLE  | CPU owns the port, waiting for TRG
    // S_RUN   | DMA issues reads in cycles the CPU leaves free
    // S_DRAIN | all reads issued, waiting for the last line-buffer writes
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

    localparam logic [8:0] LAST_IC = 9'(LEN - 1);
    localparam logic [8:0] LEN_W   = 9'(LEN);

    state_t     state_q, state_d;
    logic [8:0] ic_q, ic_d, wc_q, wc_d;
    logic       rd_q, rd_d, dwe_q, dwe_d, done_q, done_d;
    logic [7:0] dad_q, dad_d, dwd_q, dwd_d;
    logic       cpu_req, dma_own, cwait_c;
`ifdef SPDMA_FAIR_EN
    logic [1:0] sc_q, sc_d;
`endif

    always_comb begin
        cpu_req = CRD | CWR;
        dma_own = 1'b0;
        cwait_c = 1'b0;
`ifdef SPDMA_FAIR_EN
        sc_d    = 2'd0;
        if (state_q == S_RUN) begin
            if (sc_q == 2'd3) begin
                dma_own = 1'b1;
                cwait_c = cpu_req;
            end else begin
                dma_own = ~cpu_req;
                if (cpu_req) sc_d = sc_q + 2'd1;
            end
        end
`else
        if (state_q == S_RUN) dma_own = ~cpu_req;
`endif
    end

    assign MAD   = dma_own ? (SRC_BASE + {2'b00, ic_q}) : CAD;
    assign MWE   = ~dma_own & CWR;
    assign MWD   = CWD;
    assign CDO   = MRD;
    assign CWAIT = cwait_c;
    // DONE is registered, so BUSY is stretched over the DONE cycle explicitly
    assign BUSY  = (state_q != S_IDLE) | done_q;
    assign DONE  = done_q;
    assign DAD   = dad_q;
    assign DWD   = dwd_q;
    assign DWE   = dwe_q;

    always_comb begin
        state_d = state_q;
        ic_d    = ic_q;
        wc_d    = wc_q;
        rd_d    = dma_own;
        dwe_d   = rd_q;
        dad_d   = dad_q;
        dwd_d   = dwd_q;
        done_d  = 1'b0;
        if (rd_q) begin
            dad_d = wc_q[7:0];
            dwd_d = MRD;
            wc_d  = wc_q + 9'd1;
        end
        case (state_q)
            S_IDLE: begin
                ic_d = 9'd0;
                wc_d = 9'd0;
                if (TRG && !done_q) state_d = S_RUN;
            end
            S_RUN: begin
                if (dma_own) begin
                    ic_d = ic_q + 9'd1;
                    if (ic_q == LAST_IC) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (wc_q == LEN_W) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CL) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            ic_q    <= 9'd0;
            wc_q    <= 9'd0;
            rd_q    <= 1'b0;
            dwe_q   <= 1'b0;
            dad_q   <= 8'd0;
            dwd_q   <= 8'd0;
            done_q  <= 1'b0;
`ifdef SPDMA_FAIR_EN
            sc_q    <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            ic_q    <= ic_d;
            wc_q    <= wc_d;
            rd_q    <= rd_d;
            dwe_q   <= dwe_d;
            dad_q   <= dad_d;
            dwd_q   <= dwd_d;
            done_q  <= done_d;
`ifdef SPDMA_FAIR_EN
            sc_q    <= sc_d;
`endif
        end
    end
endmodule

// File: tb/tb_spdma_ctl.sv
// Bench for spdma_ctl: idle-port vector table, directed transfer sequences and random CPU
// traffic, all checked every cycle against a transaction-level model of issues and writes.
module tb_spdma_ctl;
    localparam logic [10:0] SRC = 11'h7F0;
    localparam int L = 256;
`ifdef SPDMA_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        CL = 1'b0;
    logic        RSTn, TRG, CRD, CWR;
    logic [10:0] CAD, MAD;
    logic [7:0]  CWD, CDO, MWD, MRD, DAD, DWD;
    logic        CWAIT, MWE, DWE, BUSY, DONE;

    spdma_ctl #(.SRC_BASE(SRC), .LEN(L)) dut (
        .CL(CL), .RSTn(RSTn), .TRG(TRG), .CAD(CAD), .CRD(CRD), .CWR(CWR), .CWD(CWD),
        .CDO(CDO), .CWAIT(CWAIT), .MAD(MAD), .MWE(MWE), .MWD(MWD), .MRD(MRD),
        .DAD(DAD), .DWD(DWD), .DWE(DWE), .BUSY(BUSY), .DONE(DONE));

    always #5 CL = ~CL;

    // work RAM with registered read
    logic [7:0] mem [2048];
    always @(posedge CL) begin
        if (MWE) mem[MAD] <= MWD;
        MRD <= mem[MAD];
    end

    int n_chk = 0, n_pass = 0;
    int t = 0;

    // reference model: transfer window, issue count and expected line-buffer writes by cycle
    int m_start = -1, m_done = -1, m_issued = 0, m_streak = 0;
    logic [7:0] ref_mem [2048];
    logic [7:0] e_dad [int];
    logic [7:0] e_dwd [int];
    int cdo_t = -1;
    logic [7:0] cdo_v;
    bit checks_on = 1'b0;
    int dwe_cnt = 0, done_cnt = 0, done_at = -1, first_dad = -1;

    typedef struct {
        logic        crd;
        logic        cwr;
        logic [10:0] cad;
        logic [7:0]  cwd;
        logic [10:0] e_mad;
        logic        e_mwe;
        logic [7:0]  e_mwd;
        logic        e_busy;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, t);
    endtask

    function automatic bit m_busy(input int c);
        return m_start >= 0 && c >= m_start && (m_done < 0 || c <= m_done);
    endfunction

    function automatic bit m_run(input int c);
        return m_busy(c) && m_issued < L;
    endfunction

    task automatic drive(input logic trg, input logic crd, input logic cwr,
                         input logic [10:0] cad, input logic [7:0] cwd, input logic rstn);
        TRG = trg; CRD = crd; CWR = cwr; CAD = cad; CWD = cwd; RSTn = rstn;
    endtask

    task automatic step();
        bit req, run, forced, dma;
        logic [10:0] ea;
        logic [10:0] src_a;
        @(negedge CL);
        req    = CRD | CWR;
        run    = m_run(t);
        forced = FAIR && run && (m_streak == 3);
        dma    = run && (!req || forced);
        src_a  = SRC + 11'(m_issued);
        ea     = dma ? src_a : CAD;
        if (checks_on) begin
            chk("MAD", 32'(MAD), 32'(ea));
            chk("MWE", 32'(MWE), 32'(!dma && CWR));
            if (!dma && CWR) chk("MWD", 32'(MWD), 32'(CWD));
            chk("CWAIT", 32'(CWAIT), 32'(forced && req));
            chk("BUSY", 32'(BUSY), 32'(m_busy(t)));
            chk("DONE", 32'(DONE), 32'(t == m_done));
            chk("DWE", 32'(DWE), 32'(e_dad.exists(t)));
            if (e_dad.exists(t)) begin
                chk("DAD", 32'(DAD), 32'(e_dad[t]));
                chk("DWD", 32'(DWD), 32'(e_dwd[t]));
            end
            if (cdo_t == t) chk("CDO", 32'(CDO), 32'(cdo_v));
        end
        if (DWE === 1'b1) begin
            dwe_cnt++;
            if (first_dad < 0) first_dad = int'(DAD);
        end
        if (DONE === 1'b1) begin
            done_cnt++;
            done_at = t;
        end
        @(posedge CL);
        if (!RSTn) begin
            m_start = -1; m_done = -1; m_issued = 0; m_streak = 0; cdo_t = -1;
            e_dad.delete();
            e_dwd.delete();
        end else begin
            if (dma) begin
                e_dad[t + 2] = 8'(m_issued);
                e_dwd[t + 2] = ref_mem[src_a];
                m_issued++;
                m_streak = 0;
                if (m_issued == L) m_done = t + 3;
            end else if (run) begin
                m_streak++;
            end
            if (!dma && CWR) ref_mem[CAD] = CWD;
            if (!dma && CRD && !CWR) begin
                cdo_t = t + 1;
                cdo_v = ref_mem[CAD];
            end
            if (TRG && !m_busy(t)) begin
                m_start = t + 1; m_done = -1; m_issued = 0; m_streak = 0;
            end
        end
        t++;
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b0, 11'h000, 8'h00, 1'b1);
            step();
        end
    endtask

    initial begin
        int tk;
        int p;
        tbl[0] = '{1'b0, 1'b1, 11'h7FF, 8'h3C, 11'h7FF, 1'b1, 8'h3C, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 11'h010, 8'h00, 11'h010, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 11'h020, 8'h11, 11'h020, 1'b1, 8'h11, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 11'h123, 8'h44, 11'h123, 1'b0, 8'h44, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 11'h7FF, 8'h00, 11'h7FF, 1'b0, 8'h00, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 11'h020, 8'hEE, 11'h020, 1'b0, 8'hEE, 1'b0};

        for (int i = 0; i < 2048; i++) begin
            mem[11'(i)]     = 8'(i) ^ 8'h5A;
            ref_mem[11'(i)] = 8'(i) ^ 8'h5A;
        end

        drive(1'b0, 1'b0, 1'b0, 11'h000, 8'h00, 1'b0);
        step();
        step();
        drive(1'b0, 1'b0, 1'b0, 11'h000, 8'h00, 1'b1);
        chk("rst_DWE", 32'(DWE), 32'd0);
        chk("rst_DAD", 32'(DAD), 32'd0);
        chk("rst_DWD", 32'(DWD), 32'd0);
        chk("rst_BUSY", 32'(BUSY), 32'd0);
        chk("rst_DONE", 32'(DONE), 32'd0);
        chk("rst_CWAIT", 32'(CWAIT), 32'd0);
        checks_on = 1'b1;

        // idle: CPU owns the port unconditionally
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, tbl[i].crd, tbl[i].cwr, tbl[i].cad, tbl[i].cwd, 1'b1);
            #1;
            chk("tbl_MAD", 32'(MAD), 32'(tbl[i].e_mad));
            chk("tbl_MWE", 32'(MWE), 32'(tbl[i].e_mwe));
            chk("tbl_MWD", 32'(MWD), 32'(tbl[i].e_mwd));
            chk("tbl_BUSY", 32'(BUSY), 32'(tbl[i].e_busy));
            step();
        end
        idle_cycles(2);

        // uncontended transfer
        dwe_cnt = 0; done_cnt = 0; tk = t;
        drive(1'b1, 1'b0, 1'b0, 11'h000, 8'h00, 1'b1);
        step();
        idle_cycles(L + 8);
        chk("uncont_dwe_cnt", 32'(dwe_cnt), 32'(L));
        chk("uncont_done_cnt", 32'(done_cnt), 32'd1);
        chk("uncont_done_at", 32'(done_at), 32'(tk + L + 3));

        // re-trigger in RUN, DRAIN and on the DONE cycle is ignored
        dwe_cnt = 0; done_cnt = 0; tk = t;
        for (int j = 0; j < L + 12; j++) begin
            drive((j == 0 || j == 50 || j == L + 2 || j == L + 3), 1'b0, 1'b0, 11'h000, 8'h00, 1'b1);
            step();
        end
        chk("retrg_done_cnt", 32'(done_cnt), 32'd1);
        chk("retrg_done_at", 32'(done_at), 32'(tk + L + 3));
        chk("retrg_dwe_cnt", 32'(dwe_cnt), 32'(L));

        // CPU steals 5 write cycles and one read mid-RUN
        dwe_cnt = 0; done_cnt = 0; tk = t;
        for (int j = 0; j < L + 16; j++) begin
            if (j >= 100 && j < 105) drive(1'b0, 1'b0, 1'b1, 11'h7FF, 8'hC3, 1'b1);
            else if (j == 120)       drive(1'b0, 1'b1, 1'b0, 11'h010, 8'h00, 1'b1);
            else                     drive(j == 0, 1'b0, 1'b0, 11'h000, 8'h00, 1'b1);
            step();
        end
        chk("steal_done_at", 32'(done_at), 32'(tk + L + 3 + 6));
        chk("steal_dwe_cnt", 32'(dwe_cnt), 32'(L));
        chk("steal_ram_7ff", 32'(mem[11'h7FF]), 32'h0C3);

        // CPU holds CRD through the whole transfer
        dwe_cnt = 0; done_cnt = 0; tk = t;
        if (FAIR) begin
            for (int j = 0; j < 4 * L + 8; j++) begin
                drive(j == 0, 1'b1, 1'b0, 11'h010, 8'h00, 1'b1);
                step();
            end
            chk("fair_done_at", 32'(done_at), 32'(tk + 4 * L + 3));
            chk("fair_dwe_cnt", 32'(dwe_cnt), 32'(L));
        end else begin
            for (int j = 0; j < 300; j++) begin
                drive(j == 0, 1'b1, 1'b0, 11'h010, 8'h00, 1'b1);
                step();
            end
            chk("starve_dwe_cnt", 32'(dwe_cnt), 32'd0);
            chk("starve_done_cnt", 32'(done_cnt), 32'd0);
            idle_cycles(L + 8);
            chk("starve_release_done", 32'(done_cnt), 32'd1);
        end

        // reset while wc=100
        for (int j = 0; j < 103; j++) begin
            drive(j == 0, 1'b0, 1'b0, 11'h000, 8'h00, j != 102);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 11'h000, 8'h00, 1'b1);
        chk("rstmid_BUSY", 32'(BUSY), 32'd0);
        chk("rstmid_DWE", 32'(DWE), 32'd0);
        chk("rstmid_DONE", 32'(DONE), 32'd0);
        dwe_cnt = 0; done_cnt = 0; first_dad = -1;
        drive(1'b1, 1'b0, 1'b0, 11'h000, 8'h00, 1'b1);
        step();
        idle_cycles(L + 8);
        chk("restart_first_dad", 32'(first_dad), 32'd0);
        chk("restart_dwe_cnt", 32'(dwe_cnt), 32'(L));
        chk("restart_done_cnt", 32'(done_cnt), 32'd1);

        // random CPU traffic and triggers
        for (int j = 0; j < 1600; j++) begin
            p = int'($urandom_range(0, 99));
            drive($urandom_range(0, 99) < 3, p < 15, p >= 10 && p < 25,
                  11'($urandom_range(0, 2047)), 8'($urandom), 1'b1);
            step();
        end
        idle_cycles(L + 20);
        chk("random_end_BUSY", 32'(BUSY), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/spdma_ctl.md
# spdma_ctl

Sprite-attribute DMA controller and port arbiter for one port of the 2 KB work/sprite RAM. It shares that port between the CPU and an internal DMA engine. On a trigger such as the vblank edge, the engine copies a fixed-length block from the RAM into the sprite line-buffer RAM. CPU accesses take priority; DMA uses the free cycles.

## Interface
- `SRC_BASE`, default 11'h000: DMA source base address in the work RAM.
- `LEN`, default 256: bytes per transfer; legal range 1..256.
- `CL`  in  1  clock; all logic on the rising edge.
- `RSTn`  in  1  reset, synchronous and active-low.
- `TRG`  in  1  DMA start request, sampled each cycle.
- `CAD`  in  11  CPU address.
- `CRD`  in  1  CPU read request.
- `CWR`  in  1  CPU write request.
- `CWD`  in  8  CPU write data.
- `CDO`  out  8  CPU read data.
- `CWAIT`  out  1  CPU request not granted this cycle; CPU holds the request.
- `MAD`  out  11  RAM port address (combinational).
- `MWE`  out  1  RAM port write enable (combinational).
- `MWD`  out  8  RAM port write data (combinational).
- `MRD`  in  8  RAM port read data; registered by the RAM, so 1-cycle latency.
- `DAD`  out  8  line-buffer write address (registered).
- `DWD`  out  8  line-buffer write data (registered).
- `DWE`  out  1  line-buffer write enable (registered).
- `BUSY`  out  1  transfer in progress.
- `DONE`  out  1  one-cycle pulse when a transfer completes.

## Operation
- **States:** IDLE, RUN, DRAIN.
- **IDLE:**
  - `TRG`=1 → RUN.
  - Issue counter `ic` := 0, write counter `wc` := 0.
- **RUN:**
  - Each cycle, the port owner is the CPU if `CRD|CWR`, otherwise DMA. With `SPDMA_FAIR_EN`, see Configuration.
  - A DMA-owned cycle drives `MAD`=(SRC_BASE+`ic`) mod 2048 and `MWE`=0, then increments `ic`.
  - After the issue with `ic`=LEN-1 → DRAIN.
- **DRAIN:**
  - Waits until `wc`=LEN.
  - Then → IDLE with `DONE`=1 for that one cycle.
- **CPU-owned cycle:**
  - `MAD`=`CAD`, `MWE`=`CWR`, `MWD`=`CWD`.
  - In IDLE and DRAIN the CPU always owns the port.
- **Read-owner pipeline:**
  - A 1-bit register records whether the previous cycle's issue was a DMA read.
  - If it was, the next cycle latches `DWD`=`MRD`, `DAD`=`wc`[7:0], `DWE`=1, and increments `wc`.
  - Otherwise `DWE`=0.
- **CPU read data:** `CDO`=`MRD`, valid the cycle after a granted `CRD`. `CDO` is undefined otherwise.
- **Arithmetic:**
  - `ic` and `wc` are 9-bit.
  - Source address wraps modulo 2048.
  - `DAD` is always `wc` truncated to 8 bits.
- **Boundary behaviour:**
  - `TRG` in RUN or DRAIN is ignored; no queueing.
  - `TRG` in the same cycle `DONE` pulses is ignored.
  - Simultaneous `CRD` and `CWR` is treated as a write.
  - Reset in any state → IDLE within one cycle. Counters cleared. The in-flight line-buffer write is discarded.
- **Reset values:** `DWE`=0, `DAD`=0, `DWD`=0, `BUSY`=0, `DONE`=0, `CWAIT`=0, pipeline flag=0.

## Timing
- **`BUSY`:** `TRG` sampled at edge k → `BUSY`=1 from cycle k+1 through the `DONE` cycle inclusive. `BUSY` falls the cycle after `DONE`.
- **Uncontended transfer:**
  - DMA issues in cycles k+1 .. k+LEN.
  - `DWE` in cycles k+3 .. k+LEN+2.
  - `DONE` at k+LEN+3.
- **CPU contention:** each CPU-owned cycle in RUN delays all later DMA issues, `DWE` and `DONE` by one cycle.
- **CPU latency:** write takes effect at the grant edge. Read data is on `CDO` one cycle after grant.
- **`CWAIT`:** combinational, high only in a cycle where the CPU requests and is denied.

## Configuration
- **Macro:** `SPDMA_FAIR_EN`.
- **Defined:**
  - A 2-bit starvation counter counts consecutive CPU-owned cycles in RUN.
  - When it reaches 3, the next RUN cycle is DMA-owned even if the CPU requests. `CWAIT`=1 in that cycle and the counter resets.
  - The counter also resets on any DMA-owned cycle.
- **Undefined:**
  - The CPU has absolute priority; DMA can starve indefinitely.
  - `CWAIT` is tied to 0.

## Test plan
- **Uncontended transfer:** reset, RAM[0..255]=i^8'h5A, pulse `TRG` → 256 `DWE` pulses, `DAD` 0..255 with `DWD`=`DAD`^8'h5A. `DONE` exactly LEN+3 cycles after `TRG`. `BUSY` high throughout.
- **CPU steals mid-transfer:** `CWR` `CAD`=11'h7FF `CWD`=8'hC3 for 5 cycles mid-RUN → `DONE` delayed 5 cycles. Line-buffer contents still correct. RAM[7FF]=C3.
- **CPU read during RUN:** `CRD` `CAD`=11'h010 → `CDO`=RAM[010] next cycle. No `DWE` that cycle unless a DMA read was issued the cycle before.
- **Wrap and ignored re-trigger:** SRC_BASE=11'h7F0, LEN=32. Pulse `TRG` again during RUN → sources 7F0..7FF then 000..00F. Exactly one `DONE`.
- **Fairness, `SPDMA_FAIR_EN` defined:** hold `CRD` continuously through RUN → every 4th cycle `CWAIT`=1 with a DMA issue. `DONE` at k+4·LEN+3. Without the macro, no `DWE` occurs and `CWAIT`=0 throughout.
- **Reset mid-operation:** assert `RSTn`=0 at `wc`=100 → next cycle `BUSY`=0, `DWE`=0, `DONE`=0. A fresh `TRG` restarts from `DAD`=0.
